// File: rtl/cnn_pkg.sv
// Shared constants, types and helpers for the layer-2 pooling stage.
package cnn_pkg;

    localparam int MAP_W = 11;   // feature-map width and height
    localparam int DW    = 18;   // signed data width
    localparam int AW    = 7;    // feature-map RAM address width
    localparam int OUT_W = 5;    // pooled map width and height

    typedef logic signed [DW-1:0] data_t;
    typedef logic [2:0]           win_idx_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_OUT,
        ST_DONE
    } pool_state_t;

    // Address of the top-left word of pooling window (pr, pc).
    function automatic logic [AW-1:0] win_base(input win_idx_t pr, input win_idx_t pc);
        return AW'(2 * MAP_W * int'(pr) + 2 * int'(pc));
    endfunction

endpackage

// File: rtl/max2_s.sv
// Combinational signed maximum of two words; a tie returns input a.
module max2_s
    import cnn_pkg::*;
(
    input  data_t a,
    input  data_t b,
    output data_t y
);

    // b wins only when strictly greater, so the held value survives ties
    assign y = (b > a) ? b : a;

endmodule

// File: rtl/l2_maxpool.sv
// 2x2 stride-2 signed max pooling over the 11x11 layer-2 feature map.
// Reads each window through the 1-cycle RAM and streams 25 results.
module l2_maxpool
    import cnn_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic [AW-1:0] addr_rd,
    input  logic [DW-1:0] ram_dout,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          busy,
    output logic          done
);

    pool_state_t state, state_next;
    logic [2:0]  sub;
    win_idx_t    pr, pc;
    data_t       max_r, sample, max_y;
    logic        last_win, accept;

    assign sample   = data_t'(ram_dout);
    assign last_win = (pr == win_idx_t'(OUT_W - 1)) && (pc == win_idx_t'(OUT_W - 1));
    assign accept   = out_valid && out_ready;

    max2_s u_max (
        .a (max_r),
        .b (sample),
        .y (max_y)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    // Next-state logic
    always_comb begin
        // NOTE: default assigned first so no path leaves state_next unassigned (no latch).
        state_next = state;
        unique case (state)
            ST_IDLE: if (start)         state_next = ST_READ;
            ST_READ: if (sub == 3'd4)   state_next = ST_OUT;
            ST_OUT:  if (accept)        state_next = last_win ? ST_DONE : ST_READ;
            ST_DONE:                    state_next = ST_IDLE;
            default:                    state_next = ST_IDLE;
        endcase
    end

    // Address sequencing, max accumulation, output stream and status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sub       <= '0;
            pr        <= '0;
            pc        <= '0;
            max_r     <= '0;
            addr_rd   <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        sub     <= '0;
                        pr      <= '0;
                        pc      <= '0;
                        addr_rd <= win_base('0, '0);
                        busy    <= 1'b1;
                    end
                end
                ST_READ: begin
                    sub <= sub + 3'd1;
                    // TL -> TR -> BL -> BR, then hold on BR
                    case (sub)
                        3'd0:    addr_rd <= addr_rd + AW'(1);
                        3'd1:    addr_rd <= addr_rd + AW'(MAP_W - 1);
                        3'd2:    addr_rd <= addr_rd + AW'(1);
                        default: ;
                    endcase
                    // Samples arrive two edges after their address: TL at sub=1, BR at sub=4
                    if (sub == 3'd1)      max_r <= sample;
                    else if (sub >= 3'd2) max_r <= max_y;
                    if (sub == 3'd4) begin
                        out_data  <= max_y;
                        out_valid <= 1'b1;
                        sub       <= '0;
                    end
                end
                ST_OUT: begin
                    if (accept) begin
                        out_valid <= 1'b0;
                        if (last_win) begin
                            busy <= 1'b0;
                            done <= 1'b1;
                        end else begin
                            sub <= '0;
                            if (pc == win_idx_t'(OUT_W - 1)) begin
                                pc      <= '0;
                                pr      <= pr + 3'd1;
                                addr_rd <= win_base(pr + 3'd1, '0);
                            end else begin
                                pc      <= pc + 3'd1;
                                addr_rd <= win_base(pr, pc + 3'd1);
                            end
                        end
                    end
                end
                ST_DONE: ;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_l2_maxpool.sv
// Self-checking bench for l2_maxpool: RAM model, window-max reference model,
// directed passes with randomized map contents.
module tb_l2_maxpool;
    import cnn_pkg::*;

    logic          clk = 1'b0;
    logic          rst_n, start, out_ready;
    logic [AW-1:0] addr_rd;
    logic [DW-1:0] ram_dout, out_data;
    logic          out_valid, busy, done;

    int checks = 0;
    int errors = 0;
    int hs_cnt, done_cnt, max_addr;

    logic [DW-1:0] mem [0:MAP_W*MAP_W-1];
    logic [DW-1:0] exp_q [OUT_W*OUT_W];
    logic [DW-1:0] got   [OUT_W*OUT_W];

    always #5 clk = ~clk;

    l2_maxpool dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .addr_rd   (addr_rd),
        .ram_dout  (ram_dout),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
    );

    // Layer-2 RAM: registered read
    always @(posedge clk) ram_dout <= mem[addr_rd];

    // Handshake counter
    always @(posedge clk) if (rst_n && out_valid && out_ready) hs_cnt++;

    // Done pulses and highest address seen
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (int'(addr_rd) > max_addr) max_addr = int'(addr_rd);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: signed maximum of each 2x2 stride-2 window, row-major order
    function automatic void build_model();
        for (int r = 0; r < OUT_W; r++) begin
            for (int c = 0; c < OUT_W; c++) begin
                int best = 0;
                for (int k = 0; k < 4; k++) begin
                    int v = int'($signed(mem[(2*r + k/2)*MAP_W + 2*c + k%2]));
                    if (k == 0 || v > best) best = v;
                end
                exp_q[r*OUT_W + c] = DW'(best);
            end
        end
    endfunction

    task automatic fill_ramp();
        for (int i = 0; i < MAP_W*MAP_W; i++) mem[i] = DW'(i);
    endtask

    task automatic fill_random();
        for (int i = 0; i < MAP_W*MAP_W; i++) begin
            mem[i] = DW'($urandom);
            if (mem[i] == 18'h1FFFF) mem[i] = '0;
        end
    endtask

    // One pooling pass; optional stall window, busy-start window, abort window (-1 = none)
    task automatic run_pass(input int stall_win, input int busy_start_win, input int abort_win);
        int            lat;
        logic [DW-1:0] hd;
        logic [AW-1:0] ha;
        build_model();
        hs_cnt   = 0;
        done_cnt = 0;
        max_addr = 0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        check("busy_after_start", busy, 1);
        for (int w = 0; w < OUT_W*OUT_W; w++) begin
            lat = 0;
            while (!out_valid && lat < 20) begin
                @(negedge clk);
                lat++;
                start = (w == busy_start_win) && (lat == 1);
            end
            start = 1'b0;
            check($sformatf("latency_w%0d", w), lat, 5);
            check($sformatf("data_w%0d", w), out_data, exp_q[w]);
            got[w] = out_data;
            if (w == abort_win) begin
                rst_n = 1'b0;
                #1;
                check("abort_addr", addr_rd, 0);
                check("abort_data", out_data, 0);
                check("abort_valid", out_valid, 0);
                check("abort_busy", busy, 0);
                check("abort_done", done, 0);
                @(negedge clk) rst_n = 1'b1;
                hs_cnt   = 0;
                done_cnt = 0;
                repeat (20) @(negedge clk);
                check("idle_handshakes", hs_cnt, 0);
                check("idle_valid", out_valid, 0);
                check("idle_busy", busy, 0);
                check("idle_addr", addr_rd, 0);
                check("idle_done_cnt", done_cnt, 0);
                return;
            end
            if (w == stall_win) begin
                out_ready = 1'b0;
                hd = out_data;
                ha = addr_rd;
                repeat (10) begin
                    @(negedge clk);
                    check("stall_data", out_data, hd);
                    check("stall_addr", addr_rd, ha);
                    check("stall_valid", out_valid, 1);
                end
                out_ready = 1'b1;
            end
            @(negedge clk);
            if (w < OUT_W*OUT_W - 1) check("valid_cleared", out_valid, 0);
        end
        check("done_pulse", done, 1);
        check("busy_drop", busy, 0);
        @(negedge clk);
        check("done_cleared", done, 0);
        check("handshakes", hs_cnt, OUT_W*OUT_W);
        check("done_count", done_cnt, 1);
        check("addr_bound", max_addr <= 108, 1);
    endtask

    initial begin
        int poison_hits;
        rst_n     = 1'b0;
        start     = 1'b0;
        out_ready = 1'b1;
        fill_ramp();
        repeat (2) @(negedge clk);
        check("rst_addr", addr_rd, 0);
        check("rst_data", out_data, 0);
        check("rst_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Ramp map, ready held high
        run_pass(-1, -1, -1);
        check("ramp_first", got[0], 12);
        check("ramp_row1", got[5], 34);
        check("ramp_last", got[24], 108);

        // Backpressure on window 3 and a start pulse during window 7
        run_pass(3, 7, -1);

        // Reset during window 10, then a clean pass
        run_pass(-1, -1, 10);
        run_pass(-1, -1, -1);
        check("restart_first", got[0], 12);

        // Negative data and an all-equal negative window
        fill_random();
        mem[0]  = 18'h3FFFB;
        mem[1]  = 18'h3FFFD;
        mem[11] = 18'h20000;
        mem[12] = 18'h3FFFC;
        mem[2]  = 18'h3FFFF;
        mem[3]  = 18'h3FFFF;
        mem[13] = 18'h3FFFF;
        mem[14] = 18'h3FFFF;
        run_pass(-1, -1, -1);
        check("neg_w0", got[0], 18'h3FFFD);
        check("neg_equal_w1", got[1], 18'h3FFFF);

        // Poisoned last row and column must never reach the output
        fill_random();
        for (int i = 0; i < MAP_W; i++) begin
            mem[10*MAP_W + i] = 18'h1FFFF;
            mem[i*MAP_W + 10] = 18'h1FFFF;
        end
        run_pass(-1, -1, -1);
        poison_hits = 0;
        for (int i = 0; i < OUT_W*OUT_W; i++) if (got[i] == 18'h1FFFF) poison_hits++;
        check("poison_hits", poison_hits, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
